uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the BufferedUart transmit write port (writeReq/writeAck/dataIn) among NUM_REQ independent requesters. It captures one word per grant into a holding register, acknowledges the requester immediately, and then drives the UART write handshake from that register. An optional per-requester lock keeps the grant with one requester for multi-word bursts, so frames from different sources do not interleave on tx.

---
 rtl/uart_tx_arbiter.sv | 96 +++++++++
 tb/tb_uart_tx_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing the BufferedUart transmit write port
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 11,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          busy,
  output logic [ID_W-1:0]               grantId,
  input  logic                          uartFull,
  output logic                          uartWriteReq,
  input  logic                          uartWriteAck,
  output logic [DATA_WIDTH-1:0]         uartDataIn
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, stateNext;
  logic                   lockHeld, lockNext;
  logic [NUM_REQ-1:0]     ackNext;
  logic [ID_W-1:0]        grantNext;
  logic                   writeReqNext;
  logic [DATA_WIDTH-1:0]  dataNext;
  logic [ID_W-1:0]        winner;
  logic                   lockValid;
  logic                   found;

  // A held lock wins outright; otherwise search starts just past the last grant.
  always_comb begin
    lockValid = lockHeld && req[grantId];
    winner    = grantId;
    found     = 1'b0;
    if (!lockValid) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && req[ID_W'((int'(grantId) + k) % NUM_REQ)]) begin
          winner = ID_W'((int'(grantId) + k) % NUM_REQ);
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stateNext    = state;
    lockNext     = lockHeld;
    ackNext      = '0;
    grantNext    = grantId;
    writeReqNext = uartWriteReq;
    dataNext     = uartDataIn;
    case (state)
      IDLE: begin
        if (lockHeld && !req[grantId]) lockNext = 1'b0;
        if (!uartFull && (|req)) begin
          dataNext        = data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          grantNext       = winner;
          lockNext        = lock[winner];
          ackNext[winner] = 1'b1;
          writeReqNext    = 1'b1;
          stateNext       = SEND;
        end
      end
      SEND: begin
        if (uartWriteAck) begin
          writeReqNext = 1'b0;
          stateNext    = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lockHeld     <= 1'b0;
      ack          <= '0;
      grantId      <= ID_W'(NUM_REQ - 1);
      uartWriteReq <= 1'b0;
      uartDataIn   <= '0;
    end else begin
      state        <= stateNext;
      lockHeld     <= lockNext;
      ack          <= ackNext;
      grantId      <= grantNext;
      uartWriteReq <= writeReqNext;
      uartDataIn   <= dataNext;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized and directed bench for uart_tx_arbiter against a reference model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 11;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, lock, ack;
  logic [N*W-1:0] data;
  logic           busy, uartFull, uartWriteReq, uartWriteAck;
  logic [1:0]     grantId;
  logic [W-1:0]   uartDataIn;

  int total = 0;
  int bad = 0;

  int         mGrant;
  bit         mLock, mBusy, mWreq;
  logic [N-1:0] mAck;
  logic [W-1:0] mDout;
  int         ackLog[$];

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .data(data),
    .ack(ack), .busy(busy), .grantId(grantId), .uartFull(uartFull),
    .uartWriteReq(uartWriteReq), .uartWriteAck(uartWriteAck), .uartDataIn(uartDataIn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one word in flight at most; the lock sticks only while its owner keeps requesting.
  task automatic modelStep();
    if (rst) begin
      mBusy = 0; mAck = '0; mGrant = N - 1; mLock = 0; mWreq = 0; mDout = '0;
    end else if (!mBusy) begin
      mAck = '0;
      if (mLock && !req[mGrant]) mLock = 0;
      if (!uartFull && req != '0) begin
        int w;
        w = mGrant;
        if (!mLock) begin
          for (int k = 1; k <= N; k++) begin
            if (req[(mGrant + k) % N]) begin
              w = (mGrant + k) % N;
              break;
            end
          end
        end
        mGrant = w;
        mDout  = data[w*W +: W];
        mLock  = lock[w];
        mAck   = N'(1) << w;
        mWreq  = 1;
        mBusy  = 1;
      end
    end else begin
      mAck = '0;
      if (uartWriteAck) begin
        mWreq = 0;
        mBusy = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    chk("ack", int'(ack), int'(mAck));
    chk("busy", int'(busy), int'(mBusy));
    chk("grantId", int'(grantId), mGrant);
    chk("uartWriteReq", int'(uartWriteReq), int'(mWreq));
    chk("uartDataIn", int'(uartDataIn), int'(mDout));
    for (int i = 0; i < N; i++) if (ack[i]) ackLog.push_back(i);
  endtask

  task automatic doReset();
    rst = 1; req = '0; lock = '0; uartFull = 0; uartWriteAck = 0;
    cycle();
    rst = 0;
    ackLog.delete();
  endtask

  task automatic chkSeq(input string name, input int exp0, input int exp1, input int exp2,
                        input int exp3, input int exp4);
    int e[5];
    e = '{exp0, exp1, exp2, exp3, exp4};
    chk({name, "_count_ge5"}, int'(ackLog.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_%0d", name, i), (i < ackLog.size()) ? ackLog[i] : -1, e[i]);
  endtask

  initial begin
    data = '0;
    doReset();
    chk("rst_grantId", int'(grantId), 3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wreq", int'(uartWriteReq), 0);

    // Single word from requester 0
    data[0 +: W] = 11'h0A5; req = 4'b0001;
    cycle();
    chk("single_ack", int'(ack), 1);
    chk("single_data", int'(uartDataIn), 'h0A5);
    req = '0;
    repeat (3) cycle();
    chk("single_wreq_held", int'(uartWriteReq), 1);
    uartWriteAck = 1; cycle(); uartWriteAck = 0; cycle();
    chk("single_wreq_drop", int'(uartWriteReq), 0);

    // Round robin across all four
    doReset();
    data = {11'h044, 11'h033, 11'h022, 11'h011};
    req = 4'b1111; uartWriteAck = 1;
    repeat (10) cycle();
    req = '0; repeat (2) cycle();
    chkSeq("rr", 0, 1, 2, 3, 0);

    // Lock burst on requester 2
    doReset();
    uartWriteAck = 1; req = 4'b0100; lock = 4'b0100;
    cycle();
    req = 4'b1111;
    for (int c = 0; c < 40 && ackLog.size() < 5; c++) begin
      cycle();
      if (ackLog.size() == 3 && req[2]) req[2] = 1'b0;
    end
    req = '0; lock = '0; repeat (2) cycle();
    chkSeq("lock", 2, 2, 2, 3, 0);

    // Backpressure from a full UART
    doReset();
    req = 4'b0010; uartFull = 1;
    repeat (4) begin
      cycle();
      chk("full_ack", int'(ack), 0);
      chk("full_busy", int'(busy), 0);
    end
    uartFull = 0;
    cycle();
    chk("full_release_ack", int'(ack), 2);
    req = '0; uartWriteAck = 1; cycle(); uartWriteAck = 0;

    // Slow write acknowledge with competing requests
    doReset();
    data[0 +: W] = 11'h155; req = 4'b0001;
    cycle();
    req = 4'b1111;
    repeat (20) begin
      cycle();
      chk("slow_data", int'(uartDataIn), 'h155);
      chk("slow_busy", int'(busy), 1);
      chk("slow_ack", int'(ack), 0);
    end
    uartWriteAck = 1; cycle(); uartWriteAck = 0; req = '0;
    chk("slow_done_busy", int'(busy), 0);

    // Reset in the middle of SEND
    doReset();
    req = 4'b0010; cycle(); req = '0;
    rst = 1; cycle(); rst = 0;
    chk("midrst_grantId", int'(grantId), 3);
    chk("midrst_wreq", int'(uartWriteReq), 0);
    chk("midrst_data", int'(uartDataIn), 0);
    req = 4'b0001; cycle();
    chk("midrst_ack", int'(ack), 1);
    chk("midrst_grant0", int'(grantId), 0);
    req = '0;

    // Randomized traffic
    repeat (3000) begin
      rst = ($urandom % 97) == 0;
      req = N'($urandom);
      lock = N'($urandom);
      for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
      uartFull = ($urandom % 4) == 0;
      uartWriteAck = ($urandom % 3) == 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
